// File: rtl/ram_sp_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module : ram_sp_burst_reader_if
// Brief  : Bundles the signals of the burst reader: the command handshake,
//          the single-port RAM port and the output stream.
//          master = burst reader side, slave = command source / RAM / sink.
// Rev    : 1.0  initial release
// ============================================================================
interface ram_sp_burst_reader_if #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64,
  parameter int LEN_BITS  = 8
);
  // command channel
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [ADDR_BITS-1:0]   cmd_addr_i;
  logic [LEN_BITS-1:0]    cmd_len_i;
  // RAM port
  logic                   ram_en_o;
  logic [DATA_BITS/8-1:0] ram_we_o;
  logic [ADDR_BITS-1:0]   ram_addr_o;
  logic [DATA_BITS-1:0]   ram_wdata_o;
  logic [DATA_BITS-1:0]   ram_rdata_i;
  // output stream
  logic                   m_tvalid_o;
  logic                   m_tready_i;
  logic [DATA_BITS-1:0]   m_tdata_o;
  logic                   m_tlast_o;
  // status
  logic                   busy_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, ram_rdata_i, m_tready_i,
    output cmd_ready_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
           m_tvalid_o, m_tdata_o, m_tlast_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, ram_rdata_i, m_tready_i,
    input  cmd_ready_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
           m_tvalid_o, m_tdata_o, m_tlast_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ram_sp_burst_reader.sv
`default_nettype none
// ============================================================================
// Module : ram_sp_burst_reader
// Brief  : Burst read client for a single-port block RAM with a 1-cycle
//          registered read. Takes (start address, beats-1), issues reads
//          with address wrap, and returns the words as a valid/ready stream
//          with last-beat marking. A 2-entry output buffer absorbs
//          backpressure; reads are only issued when a buffer slot is
//          guaranteed, so the RAM never needs to stall.
// Rev    : 1.0  initial release
// ============================================================================
module ram_sp_burst_reader #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64,
  parameter int LEN_BITS  = 8
) (
  input wire                    clk,
  input wire                    rstn_i,
  ram_sp_burst_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic                   ready_en;
  logic [ADDR_BITS-1:0]   addr;
  logic [LEN_BITS:0]      beats_left;     // one extra bit: len=max gives 2**LEN_BITS beats
  logic                   inflight;       // a read was issued last cycle
  logic                   inflight_last;  // ...and it was the final read of the burst
  logic [1:0]             buf_count;
  logic [DATA_BITS-1:0]   buf_data0;      // head slot, drives the stream directly
  logic [DATA_BITS-1:0]   buf_data1;
  logic                   buf_last0;
  logic                   buf_last1;

  logic                   pop;
  logic                   issue;
  logic                   last_issue;
  logic [2:0]             occupancy;

  // Slots that will be committed after this edge: stored + returning - leaving.
  assign pop        = (buf_count != 2'd0) && bus.m_tready_i;
  assign occupancy  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == S_READ) && (beats_left != '0) && (occupancy < 3'd2);
  assign last_issue = issue && (beats_left == (LEN_BITS+1)'(1));

  assign bus.cmd_ready_o = ready_en && (state == S_IDLE);
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.ram_en_o    = issue;
  assign bus.ram_addr_o  = addr;
  assign bus.ram_we_o    = '0;
  assign bus.ram_wdata_o = '0;
  assign bus.m_tvalid_o  = (buf_count != 2'd0);
  assign bus.m_tdata_o   = buf_data0;
  assign bus.m_tlast_o   = buf_last0;

  // Hold off command acceptance until the first clock after reset release.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) ready_en <= 1'b0;
    else         ready_en <= 1'b1;
  end

  // Burst control: command latch, read issue with address wrap, drain wait.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= S_IDLE;
      addr          <= '0;
      beats_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid_i && ready_en) begin
            addr       <= bus.cmd_addr_i;
            beats_left <= {1'b0, bus.cmd_len_i} + (LEN_BITS+1)'(1);
            state      <= S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            addr       <= addr + ADDR_BITS'(1);
            beats_left <= beats_left - (LEN_BITS+1)'(1);
            if (last_issue) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && buf_last0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry FIFO: capture returning read data, shift toward the head on pop.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      buf_count <= 2'd0;
      buf_data0 <= '0;
      buf_data1 <= '0;
      buf_last0 <= 1'b0;
      buf_last1 <= 1'b0;
    end else if (inflight && pop) begin
      if (buf_count == 2'd2) begin
        buf_data0 <= buf_data1;
        buf_last0 <= buf_last1;
        buf_data1 <= bus.ram_rdata_i;
        buf_last1 <= inflight_last;
      end else begin
        buf_data0 <= bus.ram_rdata_i;
        buf_last0 <= inflight_last;
      end
    end else if (pop) begin
      // slot 1 is emptied so stale tags never reach the head
      buf_data0 <= buf_data1;
      buf_last0 <= buf_last1;
      buf_data1 <= '0;
      buf_last1 <= 1'b0;
      buf_count <= buf_count - 2'd1;
    end else if (inflight) begin
      if (buf_count == 2'd0) begin
        buf_data0 <= bus.ram_rdata_i;
        buf_last0 <= inflight_last;
      end else begin
        buf_data1 <= bus.ram_rdata_i;
        buf_last1 <= inflight_last;
      end
      buf_count <= buf_count + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_burst_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_sp_burst_reader
// Brief  : Self-checking bench for ram_sp_burst_reader. A behavioural RAM
//          holds the words; each burst's expected stream is computed as
//          mem[(addr+i) mod depth], i = 0..len, last only on i = len.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_sp_burst_reader;
  localparam int ADDR_BITS = 10;
  localparam int DATA_BITS = 64;
  localparam int LEN_BITS  = 8;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [DATA_BITS-1:0] mem [DEPTH];

  ram_sp_burst_reader_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)) bus ();

  ram_sp_burst_reader #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)) dut (
    .clk    (clk),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM, 1-cycle registered read
  always @(posedge clk) if (bus.ram_en_o === 1'b1) bus.ram_rdata_i <= mem[bus.ram_addr_o];

  // Run one command and check everything about it. Inputs change on the
  // falling edge; outputs are observed 1 ns later, before the rising edge.
  task automatic do_burst(input int a, input int l, input int pct, input int stall,
                          output int beats_got, output int lasts_got);
    int beats, got, issued, cyc, wait_n, limit;
    bit done, prev_hold, exp_last;
    logic [DATA_BITS-1:0] prev_data, exp_data;
    logic prev_last;
    beats = l + 1; got = 0; issued = 0; cyc = 0; wait_n = 0; done = 0;
    prev_hold = 0; prev_data = '0; prev_last = 1'b0; lasts_got = 0;
    limit = 40 * beats + 60;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = ADDR_BITS'(a);
    bus.cmd_len_i   = LEN_BITS'(l);
    bus.m_tready_i  = 1'b0;
    #1;
    while (bus.cmd_ready_o !== 1'b1 && wait_n < 50) begin
      @(negedge clk); #1; wait_n++;
    end
    n_checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready_o=%b required 1", bus.cmd_ready_o);
      bus.cmd_valid_i = 1'b0;
      beats_got = 0;
      return;
    end
    while (!done && cyc < limit) begin
      cyc++;
      @(negedge clk);
      // commands offered mid-burst must be ignored
      bus.cmd_valid_i = 1'($urandom_range(0, 1));
      bus.cmd_addr_i  = ADDR_BITS'($urandom);
      bus.cmd_len_i   = LEN_BITS'($urandom);
      bus.m_tready_i  = (cyc > stall) && ($urandom_range(0, 99) < pct);
      #1;
      n_checks++;
      if (bus.ram_we_o !== '0 || bus.ram_wdata_o !== '0) begin
        n_fail++;
        $display("FAIL ram_write: we=%h wdata=%h required 0", bus.ram_we_o, bus.ram_wdata_o);
      end
      n_checks++;
      if (bus.busy_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_state: busy=%b cmd_ready=%b required 1/0", bus.busy_o, bus.cmd_ready_o);
      end
      n_checks++;
      if (issued - got > 2) begin
        n_fail++;
        $display("FAIL occupancy: outstanding=%0d required <=2", issued - got);
      end
      if (prev_hold) begin
        n_checks++;
        if (bus.m_tvalid_o !== 1'b1 || bus.m_tdata_o !== prev_data || bus.m_tlast_o !== prev_last) begin
          n_fail++;
          $display("FAIL hold: valid=%b data=%h last=%b required 1 %h %b",
                   bus.m_tvalid_o, bus.m_tdata_o, bus.m_tlast_o, prev_data, prev_last);
        end
      end
      if (bus.ram_en_o === 1'b1) begin
        n_checks++;
        if (issued >= beats || bus.ram_addr_o !== ADDR_BITS'(a + issued)) begin
          n_fail++;
          $display("FAIL issue: #%0d addr=%h required addr %h within %0d reads",
                   issued, bus.ram_addr_o, ADDR_BITS'(a + issued), beats);
        end
        issued++;
      end
      if (bus.m_tvalid_o === 1'b1 && bus.m_tready_i === 1'b1) begin
        exp_data = mem[(a + got) % DEPTH];
        exp_last = (got == beats - 1);
        n_checks++;
        if (bus.m_tdata_o !== exp_data || bus.m_tlast_o !== exp_last) begin
          n_fail++;
          $display("FAIL beat: #%0d data=%h last=%b required %h %b",
                   got, bus.m_tdata_o, bus.m_tlast_o, exp_data, exp_last);
        end
        if (bus.m_tlast_o === 1'b1) begin
          lasts_got++;
          done = 1;
        end
        got++;
      end
      prev_hold = (bus.m_tvalid_o === 1'b1) && !bus.m_tready_i;
      prev_data = bus.m_tdata_o;
      prev_last = bus.m_tlast_o;
    end
    beats_got = got;
    n_checks++;
    if (!done || got != beats) begin
      n_fail++;
      $display("FAIL burst_end: beats=%0d done=%0d required %0d beats", got, done, beats);
    end
    // next command must be acceptable right after the last handshake
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.m_tready_i  = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.m_tvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after: cmd_ready=%b busy=%b valid=%b required 1 0 0",
               bus.cmd_ready_o, bus.busy_o, bus.m_tvalid_o);
    end
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0; bus.m_tready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.cmd_ready_o !== 1'b0 || bus.ram_en_o !== 1'b0 || bus.ram_addr_o !== '0 ||
        bus.m_tvalid_o !== 1'b0 || bus.m_tlast_o !== 1'b0 || bus.m_tdata_o !== '0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b en=%b addr=%h v=%b l=%b d=%h busy=%b required all 0",
               bus.cmd_ready_o, bus.ram_en_o, bus.ram_addr_o, bus.m_tvalid_o, bus.m_tlast_o,
               bus.m_tdata_o, bus.busy_o);
    end
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b required 1", bus.cmd_ready_o);
    end
  endtask

  // cycle-exact latency check: addr 0x010, len 3, ready always high
  task automatic test_basic;
    bit exp_en, exp_v, exp_busy;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 10'h010; bus.cmd_len_i = 8'd3; bus.m_tready_i = 1'b1;
    #1;
    n_checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_c0: cmd_ready=%b busy=%b required 1 0", bus.cmd_ready_o, bus.busy_o);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      #1;
      exp_en   = (k >= 1 && k <= 4);
      exp_v    = (k >= 3 && k <= 6);
      exp_busy = (k <= 6);
      n_checks++;
      if (bus.ram_en_o !== exp_en || (exp_en && bus.ram_addr_o !== ADDR_BITS'(16 + k - 1))) begin
        n_fail++;
        $display("FAIL basic_ram c%0d: en=%b addr=%h required %b %h",
                 k, bus.ram_en_o, bus.ram_addr_o, exp_en, ADDR_BITS'(16 + k - 1));
      end
      n_checks++;
      if (bus.m_tvalid_o !== exp_v || bus.busy_o !== exp_busy ||
          (exp_v && (bus.m_tdata_o !== DATA_BITS'(64'h1010 + k - 3) || bus.m_tlast_o !== (k == 6)))) begin
        n_fail++;
        $display("FAIL basic_stream c%0d: v=%b d=%h l=%b busy=%b required %b %h %b %b",
                 k, bus.m_tvalid_o, bus.m_tdata_o, bus.m_tlast_o, bus.busy_o,
                 exp_v, DATA_BITS'(64'h1010 + k - 3), (k == 6), exp_busy);
      end
    end
    n_checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: cmd_ready=%b required 1", bus.cmd_ready_o);
    end
    bus.m_tready_i = 1'b0;
  endtask

  task automatic test_wrap;
    int g, ls;
    do_burst(32'h3FE, 3, 100, 0, g, ls);
  endtask

  task automatic test_stall;
    int g, ls;
    do_burst(32'h120, 7, 100, 10, g, ls);
  endtask

  task automatic test_len0;
    int g, ls;
    do_burst(32'h055, 0, 100, 0, g, ls);
    n_checks++;
    if (g != 1 || ls != 1) begin
      n_fail++;
      $display("FAIL len0: beats=%0d lasts=%0d required 1 1", g, ls);
    end
  endtask

  task automatic test_max_len;
    int g, ls;
    do_burst(32'h3F0, 255, 100, 0, g, ls);
  endtask

  task automatic test_mid_reset;
    int g, ls;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 10'h200; bus.cmd_len_i = 8'd15; bus.m_tready_i = 1'b1;
    #1;
    n_checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_accept: cmd_ready=%b required 1", bus.cmd_ready_o);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
    end
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_ready_o !== 1'b0 || bus.ram_en_o !== 1'b0 || bus.ram_addr_o !== '0 ||
        bus.m_tvalid_o !== 1'b0 || bus.m_tlast_o !== 1'b0 || bus.m_tdata_o !== '0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_values: rdy=%b en=%b addr=%h v=%b l=%b d=%h busy=%b required all 0",
               bus.cmd_ready_o, bus.ram_en_o, bus.ram_addr_o, bus.m_tvalid_o, bus.m_tlast_o,
               bus.m_tdata_o, bus.busy_o);
    end
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    bus.m_tready_i = 1'b0;
    do_burst(32'h2A0, 1, 100, 0, g, ls);
    n_checks++;
    if (g != 2 || ls != 1) begin
      n_fail++;
      $display("FAIL midrst_after: beats=%0d lasts=%0d required 2 1", g, ls);
    end
  endtask

  task automatic test_random_scoreboard;
    int a, l, g, ls;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
      do_burst(a, l, 50, 0, g, ls);
    end
  endtask

  task automatic test_random_integrity;
    int a, l, g, ls, exp_beats, got_beats, lasts;
    exp_beats = 0; got_beats = 0; lasts = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 49) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
      do_burst(a, l, 50, 0, g, ls);
      exp_beats += l + 1;
      got_beats += g;
      lasts     += ls;
    end
    n_checks++;
    if (got_beats != exp_beats || lasts != 1000) begin
      n_fail++;
      $display("FAIL integrity: beats=%0d lasts=%0d required %0d 1000", got_beats, lasts, exp_beats);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_BITS'(64'h1000 + i);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_len0();
    test_mid_reset();
    test_max_len();
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    test_random_scoreboard();
    test_random_integrity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ram_sp_burst_reader.md
Name: ram_sp_burst_reader

Overview:
- Master-side client of the single-port byte-enable block RAM (1-cycle registered read latency).
- Accepts a burst read command (start address, beat count) and drives the RAM port.
- Returns the read words as a valid/ready stream with last-beat marking.
- Absorbs downstream backpressure with a 2-entry output buffer, so the RAM never needs a stall input.

Parameters:
- ADDR_BITS, 10, RAM address width; addresses wrap modulo 2**ADDR_BITS.
- DATA_BITS, 64, RAM/stream data width; must be a multiple of 8.
- LEN_BITS, 8, command length width; burst beats = cmd_len_i + 1.

Ports:
- clk  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready; high only in IDLE
- cmd_addr_i  in  ADDR_BITS  start word address
- cmd_len_i  in  LEN_BITS  beats minus one
- ram_en_o  out  1  RAM enable (read strobe)
- ram_we_o  out  DATA_BITS/8  RAM byte write enables; constant 0
- ram_addr_o  out  ADDR_BITS  RAM address
- ram_wdata_o  out  DATA_BITS  RAM write data; constant 0
- ram_rdata_i  in  DATA_BITS  RAM read data; valid the cycle after ram_en_o
- m_tvalid_o  out  1  stream valid
- m_tready_i  in  1  stream ready
- m_tdata_o  out  DATA_BITS  stream data
- m_tlast_o  out  1  final beat of the burst
- busy_o  out  1  high whenever not IDLE

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: cmd_ready_o=0 while rstn_i is low, 1 from the first cycle after release. ram_en_o=0, ram_addr_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, busy_o=0.
  - Internal state: FSM returns to IDLE; buffer, in-flight flag, address and beat counters clear.
- States:
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr, set beats_left = cmd_len_i+1, go to READ.
  - READ: issue reads. When the last read issues, go to DRAIN.
  - DRAIN: wait until the beat with m_tlast_o=1 is accepted (m_tvalid_o & m_tready_i), then go to IDLE.
  - A new command is accepted no earlier than the cycle after that last handshake.
- Issue rule (READ state only):
  - ram_en_o=1 iff beats_left>0 and (buf_count + inflight − pop) < 2.
  - pop = m_tvalid_o & m_tready_i in the same cycle.
  - This guarantees the buffer never overflows and sustains 1 beat/cycle while m_tready_i stays high.
- Per issue:
  - ram_addr_o = current address; then address increments with wrap (2**ADDR_BITS−1 → 0).
  - beats_left decrements; inflight is set for the next cycle.
- Capture:
  - In the cycle after an issue, ram_rdata_i is pushed into the buffer.
  - The tag last = (this was the final issued read) is pushed with it.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
- Output: m_tdata_o and m_tlast_o come from the buffer head; m_tvalid_o = (buf_count != 0). All are registered, with no combinational path from ram_rdata_i.
- Stream rules:
  - Once asserted, m_tvalid_o, m_tdata_o and m_tlast_o hold stable until accepted.
  - Beats leave in address order.
  - Exactly cmd_len_i+1 beats per command; the final one has m_tlast_o=1.
- Latency: command handshake in cycle 0 → ram_en_o in cycle 1 → rdata in cycle 2 → m_tvalid_o in cycle 3.
- Boundaries:
  - cmd_len_i=0: single beat with m_tlast_o=1.
  - cmd_len_i=2**LEN_BITS−1: 2**LEN_BITS beats; the counter is LEN_BITS+1 wide.
  - Burst crossing the top address wraps to 0.
  - cmd_valid_i outside IDLE is ignored (cmd_ready_o=0).
  - m_tready_i held low indefinitely: at most 2 beats buffered; ram_en_o stays 0.
- Reset mid-burst: everything returns to reset values immediately. Outstanding beats are discarded and no m_tlast_o is produced.

Test Plan:
- Command addr=0x010, len=3, RAM preloaded with word i = 0x1000+i; m_tready_i=1 → ram_en_o cycles 1-4; beats 0x1010..0x1013 on cycles 3-6; m_tlast_o only on 0x1013; busy_o falls after cycle 6.
- Command addr=0x3FE, len=3 (ADDR_BITS=10) → ram_addr_o sequence 0x3FE, 0x3FF, 0x000, 0x001; data returned in that order.
- Command len=7 with m_tready_i low for cycles 0-10, then high → no more than 2 reads issued before the first pop; m_tdata_o stable while stalled; all 8 beats delivered in order.
- Random m_tready_i (50%) over 1000 bursts of random addr/len → scoreboard match.
- Random m_tready_i (50%) over 1000 bursts, checks → no beat lost or duplicated, m_tlast_o count = command count, ram_we_o always 0.
- len=0 at addr=0x055 → one beat equal to mem[0x055] with m_tlast_o=1; next command accepted the cycle after the handshake.
- Assert rstn_i low during cycle 4 of a len=15 burst → all outputs at reset values; after release a fresh len=1 burst completes correctly with exactly 2 beats.
